// File: rtl/panda_icb_pkg.sv
// Shared ICB definitions: bus field widths, the response-buffer entry
// type and a pointer-width helper used by the ordered response FIFO.
`timescale 1ns/1ps
package panda_icb_pkg;

    localparam int ICB_ADDR_W = 32;
    localparam int ICB_DATA_W = 32;
    localparam int ICB_MASK_W = 4;

    // One queued response: read data (zero for writes and errors) plus error flag.
    typedef struct packed {
        logic [ICB_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_entry_t;

    // Pointer width for a buffer of the given depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/icb_rsp_fifo.sv
// Ordered response buffer with first-word-fall-through output: the head
// entry is visible on o_data whenever o_empty is low. Pointers wrap
// explicitly at DEPTH, so any depth works; the occupancy counter tells
// full from empty.
`timescale 1ns/1ps
module icb_rsp_fifo
    import panda_icb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  rsp_entry_t i_data,
    input  logic       i_pop,
    output logic       o_empty,
    output rsp_entry_t o_data
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    rsp_entry_t      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage write; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/icb_imem_responder.sv
// ICB slave in front of a 1-cycle-latency instruction memory.
// Commands are credit-gated to OUTSTANDING_N in flight; every accepted
// command yields exactly one response, returned in order through
// icb_rsp_fifo. Out-of-range addresses never touch memory and answer
// with err=1, rdata=0.
// Optional: define ICB_IMEM_TOHOST_DETECT_EN to add the tohost_hit port,
// a registered one-cycle pulse on any handshake to TO_HOST_ADDR.
`timescale 1ns/1ps
module icb_imem_responder
    import panda_icb_pkg::*;
#(
    parameter int          MEM_DEPTH     = 8192,
    parameter int          OUTSTANDING_N = 4,
    parameter logic [31:0] TO_HOST_ADDR  = 32'h3000,
    parameter int          SIM_DELAY     = 1,
    localparam int         AW            = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ICB_IMEM_TOHOST_DETECT_EN
    output logic                  tohost_hit,
`endif
    input  logic [ICB_ADDR_W-1:0] s_icb_cmd_addr,
    input  logic                  s_icb_cmd_read,
    input  logic [ICB_DATA_W-1:0] s_icb_cmd_wdata,
    input  logic [ICB_MASK_W-1:0] s_icb_cmd_wmask,
    input  logic                  s_icb_cmd_valid,
    output logic                  s_icb_cmd_ready,
    output logic [ICB_DATA_W-1:0] s_icb_rsp_rdata,
    output logic                  s_icb_rsp_err,
    output logic                  s_icb_rsp_valid,
    input  logic                  s_icb_rsp_ready,
    output logic                  mem_en,
    output logic [ICB_MASK_W-1:0] mem_wen,
    output logic [AW-1:0]         mem_addr,
    output logic [ICB_DATA_W-1:0] mem_din,
    input  logic [ICB_DATA_W-1:0] mem_dout
);

    localparam int          CW             = $clog2(OUTSTANDING_N + 1);
    localparam logic [33:0] MEM_BYTES      = 34'(MEM_DEPTH) << 2;
    // SIM_DELAY only matters to behavioural memory models; kept for interface compatibility.
    localparam logic [31:0] SIM_DELAY_BITS = 32'(SIM_DELAY);

    logic [CW-1:0] r_cnt;
    logic          r_p1_valid;
    logic          r_p1_rd;
    logic          r_p1_err;

    logic          w_cmd_hs;
    logic          w_rsp_hs;
    logic          w_in_range;
    logic          w_fifo_empty;
    rsp_entry_t    w_push_data;
    rsp_entry_t    w_head;

    // A credit is free while fewer than OUTSTANDING_N commands await their response.
    assign s_icb_cmd_ready = !rst && (r_cnt < CW'(OUTSTANDING_N));
    assign w_cmd_hs        = s_icb_cmd_valid && s_icb_cmd_ready;
    assign w_rsp_hs        = s_icb_rsp_valid && s_icb_rsp_ready;
    assign w_in_range      = ({2'b00, s_icb_cmd_addr} < MEM_BYTES);

    // Memory strobe is issued in the handshake cycle itself; errors never reach memory.
    always_comb begin
        mem_en   = 1'b0;
        mem_wen  = '0;
        mem_addr = s_icb_cmd_addr[2 +: AW];
        mem_din  = s_icb_cmd_wdata;
        if (w_cmd_hs && w_in_range) begin
            mem_en  = 1'b1;
            mem_wen = s_icb_cmd_read ? '0 : s_icb_cmd_wmask;
        end
    end

    // One-stage tracker aligning command attributes with the memory's read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_rd    <= 1'b0;
            r_p1_err   <= 1'b0;
        end else begin
            r_p1_valid <= w_cmd_hs;
            r_p1_rd    <= w_cmd_hs && s_icb_cmd_read && w_in_range;
            r_p1_err   <= w_cmd_hs && !w_in_range;
        end
    end

    assign w_push_data.rdata = r_p1_rd ? mem_dout : '0;
    assign w_push_data.err   = r_p1_err;

    // Credit gating bounds the tracker plus buffer to OUTSTANDING_N entries, so no overflow.
    icb_rsp_fifo #(
        .DEPTH (OUTSTANDING_N)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_p1_valid),
        .i_data  (w_push_data),
        .i_pop   (w_rsp_hs),
        .o_empty (w_fifo_empty),
        .o_data  (w_head)
    );

    assign s_icb_rsp_valid = !rst && !w_fifo_empty;
    assign s_icb_rsp_rdata = s_icb_rsp_valid ? w_head.rdata : '0;
    assign s_icb_rsp_err   = s_icb_rsp_valid && w_head.err;

    // In-flight credit counter: simultaneous accept and retire cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({w_cmd_hs, w_rsp_hs})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef ICB_IMEM_TOHOST_DETECT_EN
    logic r_tohost_hit;

    // Registered host-signal detector; fires for reads and writes alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tohost_hit <= 1'b0;
        end else begin
            r_tohost_hit <= w_cmd_hs && (s_icb_cmd_addr == TO_HOST_ADDR);
        end
    end

    assign tohost_hit = r_tohost_hit && !rst;

    logic w_unused;
    assign w_unused = ^{s_icb_cmd_addr[1:0], SIM_DELAY_BITS[0]};
`else
    logic w_unused;
    assign w_unused = ^{s_icb_cmd_addr[1:0], SIM_DELAY_BITS[0], TO_HOST_ADDR};
`endif

endmodule

// File: tb/tb_icb_imem_responder.sv
// Scoreboard bench for icb_imem_responder: a reference memory predicts each
// response when its command is accepted; a monitor pops and compares on
// every response handshake. Define ICB_IMEM_TOHOST_DETECT_EN to also
// exercise the host-signal pulse.
`timescale 1ns/1ps
module tb_icb_imem_responder;
    import panda_icb_pkg::*;

    localparam int          MEM_DEPTH = 8192;
    localparam int          OUT_N     = 4;
    localparam logic [31:0] TOHOST    = 32'h3000;
    localparam int          AW        = $clog2(MEM_DEPTH);

    logic        clk;
    logic        rst;
    logic [31:0] s_icb_cmd_addr;
    logic        s_icb_cmd_read;
    logic [31:0] s_icb_cmd_wdata;
    logic [3:0]  s_icb_cmd_wmask;
    logic        s_icb_cmd_valid;
    logic        s_icb_cmd_ready;
    logic [31:0] s_icb_rsp_rdata;
    logic        s_icb_rsp_err;
    logic        s_icb_rsp_valid;
    logic        s_icb_rsp_ready;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
`ifdef ICB_IMEM_TOHOST_DETECT_EN
    logic        tohost_hit;
    int          n_hit = 0;
`endif

    icb_imem_responder #(
        .MEM_DEPTH     (MEM_DEPTH),
        .OUTSTANDING_N (OUT_N),
        .TO_HOST_ADDR  (TOHOST),
        .SIM_DELAY     (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef ICB_IMEM_TOHOST_DETECT_EN
        .tohost_hit      (tohost_hit),
`endif
        .s_icb_cmd_addr  (s_icb_cmd_addr),
        .s_icb_cmd_read  (s_icb_cmd_read),
        .s_icb_cmd_wdata (s_icb_cmd_wdata),
        .s_icb_cmd_wmask (s_icb_cmd_wmask),
        .s_icb_cmd_valid (s_icb_cmd_valid),
        .s_icb_cmd_ready (s_icb_cmd_ready),
        .s_icb_rsp_rdata (s_icb_rsp_rdata),
        .s_icb_rsp_err   (s_icb_rsp_err),
        .s_icb_rsp_valid (s_icb_rsp_valid),
        .s_icb_rsp_ready (s_icb_rsp_ready),
        .mem_en          (mem_en),
        .mem_wen         (mem_wen),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] phys_mem [MEM_DEPTH];
    logic [31:0] ref_mem  [MEM_DEPTH];
    rsp_entry_t  sb_q [$];
    rsp_entry_t  mon_e;
    int n_checks = 0;
    int n_pass   = 0;
    int n_unexp  = 0;
    int n_stall  = 0;
    int n_rsp    = 0;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    // Behavioural memory with one-cycle registered read and byte write enables.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) phys_mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            mem_dout <= phys_mem[mem_addr];
        end
    end

    // Response monitor: compare each handshaken response with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && s_icb_rsp_valid && s_icb_rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_unexp++;
                $display("rsp unexpected rdata=%h err=%b", s_icb_rsp_rdata, s_icb_rsp_err);
            end else begin
                mon_e = sb_q.pop_front();
                n_rsp++;
                $display("rsp %0d rdata=%h err=%b", n_rsp, s_icb_rsp_rdata, s_icb_rsp_err);
                check("rsp_rdata", s_icb_rsp_rdata, mon_e.rdata);
                check("rsp_err", 32'(s_icb_rsp_err), 32'(mon_e.err));
            end
        end
`ifdef ICB_IMEM_TOHOST_DETECT_EN
        if (tohost_hit) n_hit++;
`endif
    end

    // Drive one command, wait (bounded) for acceptance, predict its response.
    task automatic issue(input logic [31:0] addr, input logic rd,
                         input logic [31:0] wd, input logic [3:0] wm);
        rsp_entry_t e;
        logic       inr;
        int         w;
        int         k;
        s_icb_cmd_addr  = addr;
        s_icb_cmd_read  = rd;
        s_icb_cmd_wdata = wd;
        s_icb_cmd_wmask = wm;
        s_icb_cmd_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_icb_cmd_ready) break;
            n_stall++;
            @(posedge clk); #1;
        end
        if (!s_icb_cmd_ready) begin
            check("cmd_accept_timeout", 32'(s_icb_cmd_ready), 32'd1);
        end else begin
            inr = ({32'd0, addr} < 64'(MEM_DEPTH) * 64'd4);
            check("mem_en", 32'(mem_en), 32'(inr));
            check("mem_wen", 32'(mem_wen), (inr && !rd) ? 32'(wm) : 32'd0);
            w = int'(addr[2 +: AW]);
            e.rdata = '0;
            e.err   = 1'b0;
            if (!inr) e.err = 1'b1;
            else if (rd) e.rdata = ref_mem[w];
            else
                for (int b = 0; b < 4; b++)
                    if (wm[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            sb_q.push_back(e);
            $display("cmd %s addr=%h wdata=%h wmask=%b", rd ? "rd" : "wr", addr, wd, wm);
        end
        @(posedge clk); #1;
        s_icb_cmd_valid = 1'b0;
    endtask

    // Wait (bounded) until every predicted response has been seen.
    task automatic drain(input string tag);
        for (int k = 0; k < 300 && sb_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    // Fill all credits with rsp_ready low, check gating and hold, then release.
    task automatic fill_and_release(input logic [31:0] base);
        int s0;
        s_icb_rsp_ready = 1'b0;
        s0 = n_stall;
        for (int i = 0; i < OUT_N; i++) issue(base + 32'(4 * i), 1'b1, 32'd0, 4'd0);
        check("fill_stalls", 32'(n_stall - s0), 32'd0);
        @(negedge clk);
        check("full_cmd_ready", 32'(s_icb_cmd_ready), 32'd0);
        check("full_rsp_valid", 32'(s_icb_rsp_valid), 32'd1);
        check("hold_rdata_0", s_icb_rsp_rdata, sb_q[0].rdata);
        repeat (2) @(negedge clk);
        check("hold_valid", 32'(s_icb_rsp_valid), 32'd1);
        check("hold_rdata_2", s_icb_rsp_rdata, sb_q[0].rdata);
        @(posedge clk); #1;
        s_icb_rsp_ready = 1'b1;
        @(negedge clk);
        check("still_full", 32'(s_icb_cmd_ready), 32'd0);
        @(negedge clk);
        check("credit_back", 32'(s_icb_cmd_ready), 32'd1);
        @(posedge clk); #1;
        drain("fill_drain");
    endtask

    initial begin : main
        int s0;
        bit done;
        logic [31:0] ra;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            phys_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
        mem_dout        = '0;
        rst             = 1'b1;
        s_icb_cmd_addr  = '0;
        s_icb_cmd_read  = 1'b1;
        s_icb_cmd_wdata = '0;
        s_icb_cmd_wmask = '0;
        s_icb_cmd_valid = 1'b1;   // offered during reset: must be ignored
        s_icb_rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(s_icb_cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(s_icb_rsp_valid), 32'd0);
        check("rst_rdata", s_icb_rsp_rdata, 32'd0);
        check("rst_err", 32'(s_icb_rsp_err), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
`ifdef ICB_IMEM_TOHOST_DETECT_EN
        check("rst_tohost", 32'(tohost_hit), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        s_icb_cmd_valid = 1'b0;
        @(negedge clk);
        check("first_cmd_ready", 32'(s_icb_cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Single read of word 0: two-cycle latency
        issue(32'h0, 1'b1, 32'd0, 4'd0);
        @(negedge clk);
        check("lat_t1_valid", 32'(s_icb_rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_t2_valid", 32'(s_icb_rsp_valid), 32'd1);
        check("lat_t2_rdata", s_icb_rsp_rdata, 32'h0000_0013);
        @(posedge clk); #1;
        drain("single_drain");

        // Credit exhaustion and in-order release
        fill_and_release(32'h0);

        // Partial write then read-back
        issue(32'h10, 1'b0, 32'hDEAD_BEEF, 4'b0011);
        issue(32'h10, 1'b1, 32'd0, 4'd0);
        drain("wmask_drain");

        // Out-of-range read and write
        issue(32'(MEM_DEPTH * 4), 1'b1, 32'd0, 4'd0);
        issue(32'hFFFF_FFF0, 1'b0, 32'h1234_5678, 4'hF);
        issue(32'(MEM_DEPTH * 4 - 4), 1'b1, 32'd0, 4'd0);
        drain("oor_drain");

`ifdef ICB_IMEM_TOHOST_DETECT_EN
        s0 = n_hit;
        issue(TOHOST, 1'b0, 32'd1, 4'hF);
        issue(TOHOST + 32'd4, 1'b1, 32'd0, 4'd0);
        repeat (4) @(posedge clk);
        #1;
        check("tohost_pulses", 32'(n_hit - s0), 32'd1);
        drain("tohost_drain");
`endif

        // Full throughput: back-to-back commands with rsp_ready held high
        s0 = n_stall;
        for (int i = 0; i < 16; i++)
            issue(32'h100 + 32'(4 * i), (i % 3) != 0, 32'hA5A5_0000 + 32'(i), 4'hF);
        check("throughput_stalls", 32'(n_stall - s0), 32'd0);
        drain("tput_drain");

        // Random mix with random response backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    ra = ($urandom_range(0, 15) == 0) ? 32'h0001_0000 + 32'(4 * i)
                                                      : 32'(4 * $urandom_range(0, 31));
                    issue(ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    s_icb_rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        s_icb_rsp_ready = 1'b1;
        drain("rand_drain");

        // Reset with responses queued
        s_icb_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(32'h20 + 32'(4 * i), 1'b1, 32'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("queued_valid", 32'(s_icb_rsp_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(s_icb_rsp_valid), 32'd0);
        @(negedge clk);
        check("midrst_valid_2", 32'(s_icb_rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(s_icb_cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        s_icb_rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(s_icb_cmd_ready), 32'd1);
        check("post_rst_valid", 32'(s_icb_rsp_valid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        fill_and_release(32'h40);
        check("unexpected_rsp", 32'(n_unexp), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icb_imem_responder.md
ICB_IMEM_RESPONDER -- requirements
Module: icb_imem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 8192, memory depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter OUTSTANDING_N, default 4, maximum in-flight commands (1 | 2 | 4 | 8).
REQ-003 SHALL have parameter TO_HOST_ADDR, default 32'h3000, host-signal byte address.
REQ-004 SHALL have parameter SIM_DELAY, default 1, register update delay in ns (simulation only).
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have the ICB command ports: s_icb_cmd_addr in 32; s_icb_cmd_read in 1 (1=read); s_icb_cmd_wdata in 32; s_icb_cmd_wmask in 4; s_icb_cmd_valid in 1; s_icb_cmd_ready out 1.
REQ-007 SHALL have the ICB response ports: s_icb_rsp_rdata out 32; s_icb_rsp_err out 1; s_icb_rsp_valid out 1; s_icb_rsp_ready in 1.
REQ-008 SHALL have the memory ports (1-cycle read latency): mem_en out 1; mem_wen out 4; mem_addr out clog2(MEM_DEPTH); mem_din out 32; mem_dout in 32.
REQ-009 SHALL have the port tohost_hit  out  1, a one-cycle pulse (present only under the macro in REQ-024).

Function
REQ-010 SHALL assert s_icb_cmd_ready when credit count cnt < OUTSTANDING_N; cnt = commands accepted minus responses handshaken.
REQ-011 SHALL update cnt +1 on command handshake only, -1 on response handshake only, unchanged when both occur in the same cycle.
REQ-012 SHALL address memory with word index addr[2+:clog2(MEM_DEPTH)]; addr[1:0] ignored.
REQ-013 SHALL treat addr >= MEM_DEPTH*4 as out of range: no memory access (mem_en=0), response err=1, rdata=0.
REQ-014 SHALL, on an in-range handshake in cycle T, drive mem_en=1 combinationally in T, with mem_wen=wmask for writes and 4'b0000 for reads.
REQ-015 SHALL capture mem_dout (reads) or 0 (writes/errors) with err into the response FIFO at the end of T+1; s_icb_rsp_valid SHALL be high no earlier than T+2 (fixed latency 2 when the FIFO is empty).
REQ-016 SHALL return responses in strict command order through a response FIFO of depth OUTSTANDING_N; the FIFO SHALL never overflow because of credit gating (REQ-010).
REQ-017 SHALL hold s_icb_rsp_valid/rdata/err stable while rsp_valid=1 and rsp_ready=0.
REQ-018 SHALL sustain one command and one response per cycle when rsp_ready is held high (full throughput).
REQ-019 SHALL keep s_icb_rsp_valid=0 when the FIFO is empty; a FIFO wrap-around of its read/write pointers SHALL be transparent.
REQ-020 SHALL pulse tohost_hit for one cycle on any command handshake with addr == TO_HOST_ADDR (read or write).

Reset
REQ-021 SHALL, while rst=1, clear cnt, FIFO pointers, and the pipeline valid bit; outputs s_icb_cmd_ready=0, s_icb_rsp_valid=0, rdata=0, err=0, mem_en=0, tohost_hit=0.
REQ-022 SHALL discard all in-flight commands and queued responses when rst is asserted mid-operation; memory contents are not cleared.
REQ-023 SHALL assert s_icb_cmd_ready in the first cycle after rst deasserts.

Configuration
REQ-024 SHALL compile in the tohost_hit port and its comparator only when macro ICB_IMEM_TOHOST_DETECT_EN is defined; without it the port and logic SHALL be absent and TO_HOST_ADDR unused.

Structure
REQ-025 SHALL place the ICB command/response field widths and the rsp_entry_t struct (rdata, err) in the shared package panda_icb_pkg.
REQ-026 SHALL implement the ordered response buffer as sub-module icb_rsp_fifo (parameterised depth, first-word-fall-through output).

Verification
REQ-027 SHALL verify: after reset, read addr 0x0 with mem word 0 = 0x00000013, rsp_ready=1 -> rsp_valid at T+2, rdata=0x00000013, err=0.
REQ-028 SHALL verify: 4 back-to-back reads 0x0,0x4,0x8,0xC, rsp_ready=0 -> cmd_ready drops after 4th accept; release rsp_ready -> 4 in-order responses, cmd_ready returns the cycle after first response handshake.
REQ-029 SHALL verify: write 0xDEADBEEF wmask 4'b0011 to 0x10, then read 0x10 -> rdata low half 0xBEEF, upper half unchanged.
REQ-030 SHALL verify: read addr MEM_DEPTH*4 -> mem_en=0, rsp err=1, rdata=0.
REQ-031 SHALL verify: with macro defined, write to 0x3000 -> tohost_hit high exactly one cycle; without macro, port absent and build clean.
REQ-032 SHALL verify: rst asserted with 3 responses queued -> rsp_valid=0 next cycle, cnt=0, no stale response after release.
